sync_ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the 16x8 synchronous single-port RAM (shared bidirectional data bus, write on we=1, combinational read drive on we=0).
- Accepts read/write requests from two requesters and serialises them onto the RAM's we/addr/data pins.
- Owns bus direction; also sequences a whole-memory clear through the RAM's synchronous reset.

---
 rtl/sync_ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sync_ram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_arbiter.sv
// rtl/sync_ram_arbiter.sv - two-port round-robin arbiter/sequencer for a 16x8 single-port RAM
// Every output is registered; ram_data is driven only while ram_we is high.
module sync_ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_done,
  output logic                  busy,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid,
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CLR  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  port_q, port_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_rst_q, ram_rst_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  clr_done_q, clr_done_d;
  logic                  busy_q, busy_d;
  logic                  sel;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    port_d     = port_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_rst_d  = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rv0_d      = 1'b0;
    rv1_d      = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    clr_done_d = 1'b0;
    sel        = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLR;
          ram_rst_d = 1'b1;
        end else if (p0_req || p1_req) begin
          // rr_q names the port that wins a tie; the loser is preferred next time
          sel        = (p0_req && p1_req) ? rr_q : p1_req;
          rr_d       = ~sel;
          port_d     = sel;
          ram_we_d   = sel ? p1_wr : p0_wr;
          ram_addr_d = sel ? p1_addr : p0_addr;
          wdata_d    = sel ? p1_wdata : p0_wdata;
          gnt0_d     = ~sel;
          gnt1_d     = sel;
          state_d    = ACC;
        end
      end
      ACC: begin
        state_d = IDLE;
        if (!ram_we_q) begin
          if (port_q) begin
            rdata1_d = ram_data;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = ram_data;
            rv0_d    = 1'b1;
          end
        end
      end
      CLR: begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      port_q     <= 1'b0;
      wdata_q    <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_rst_q  <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      port_q     <= port_d;
      wdata_q    <= wdata_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_rst_q  <= ram_rst_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
    end
  end

  // The RAM drives the bus whenever we is low, so ram_we_q alone gates our driver
  assign ram_data  = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign ram_we    = ram_we_q;
  assign ram_rst   = ram_rst_q;
  assign ram_addr  = ram_addr_q;
  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign clr_done  = clr_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// tb/tb_sync_ram_arbiter.sv - scoreboard bench for sync_ram_arbiter with a 16x8 RAM model
module tb_sync_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_req = 1'b0;
  logic       clr_done, busy;
  logic       p0_req = 1'b0, p0_wr = 1'b0;
  logic [3:0] p0_addr = '0;
  logic [7:0] p0_wdata = '0;
  logic       p0_gnt, p0_rvalid;
  logic [7:0] p0_rdata;
  logic       p1_req = 1'b0, p1_wr = 1'b0;
  logic [3:0] p1_addr = '0;
  logic [7:0] p1_wdata = '0;
  logic       p1_gnt, p1_rvalid;
  logic [7:0] p1_rdata;
  logic       ram_rst, ram_we;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;

  always #5 clk = ~clk;

  sync_ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .ram_rst(ram_rst), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // RAM model: synchronous clear and write, combinational read drive while we is low
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
  end
  assign ram_data = ram_we ? 8'hzz : mem[ram_addr];

  typedef struct {
    int         kind;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] rdq0[$];
  logic [7:0] rdq1[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected event/read stream whenever the DUT presents one
  ev_t  e;
  logic prev_rst = 1'b0;
  logic prev_g0_rd = 1'b0, prev_g1_rd = 1'b0;
  always @(negedge clk) begin
    if (!ram_we) check("bus_read_drive", {24'd0, ram_data}, {24'd0, mem[ram_addr]});
    check("we_rst_overlap", {31'd0, ram_we & ram_rst}, 32'd0);
    check("ram_rst_single", {31'd0, ram_rst & prev_rst}, 32'd0);
    if (p0_gnt || p1_gnt || clr_done) begin
      if (evq.size() == 0) begin
        check("unexpected_event", {29'd0, p0_gnt, p1_gnt, clr_done}, 32'd0);
      end else begin
        e = evq.pop_front();
        if (e.kind == 2) begin
          check("clr_done_event", {31'd0, clr_done}, 32'd1);
          check("clr_follows_ram_rst", {31'd0, prev_rst}, 32'd1);
        end else begin
          check("gnt_port", {30'd0, p1_gnt, p0_gnt}, (e.kind == 0) ? 32'd1 : 32'd2);
          check("acc_we", {31'd0, ram_we}, {31'd0, e.wr});
          check("acc_addr", {28'd0, ram_addr}, {28'd0, e.addr});
          check("acc_busy", {31'd0, busy}, 32'd1);
          if (e.wr) check("acc_wdata", {24'd0, ram_data}, {24'd0, e.data});
        end
      end
    end
    if (p0_rvalid) begin
      check("p0_rvalid_timing", {31'd0, prev_g0_rd}, 32'd1);
      if (rdq0.size() == 0) check("p0_unexpected_rvalid", 32'd1, 32'd0);
      else check("p0_rdata", {24'd0, p0_rdata}, {24'd0, rdq0.pop_front()});
    end
    if (p1_rvalid) begin
      check("p1_rvalid_timing", {31'd0, prev_g1_rd}, 32'd1);
      if (rdq1.size() == 0) check("p1_unexpected_rvalid", 32'd1, 32'd0);
      else check("p1_rdata", {24'd0, p1_rdata}, {24'd0, rdq1.pop_front()});
    end
    prev_rst   = ram_rst;
    prev_g0_rd = p0_gnt & ~ram_we;
    prev_g1_rd = p1_gnt & ~ram_we;
  end

  // Issue one request, hold it until granted, then drop it; n counts negedges waited
  task automatic access(input int p, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, output int n);
    evq.push_back('{kind: p, wr: wr, addr: a, data: d});
    if (!wr) begin
      if (p == 0) rdq0.push_back(exp_rd);
      else rdq1.push_back(exp_rd);
    end
    if (p == 0) begin
      p0_wr = wr; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
    end else begin
      p1_wr = wr; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if ((p == 0 && p0_gnt) || (p == 1 && p1_gnt)) break;
    end
    if (n >= 20) check("gnt_timeout", 32'd0, 32'd1);
    if (p == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_rst", {31'd0, ram_rst}, 32'd0);
    check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    check("rst_rdata", {16'd0, p1_rdata, p0_rdata}, 32'd0);
    check("rst_clr_done", {31'd0, clr_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: write then read back on port 0, single-cycle grant latency
    access(0, 1'b1, 4'd3, 8'hA5, 8'h00, n);
    check("t1_wr_latency", n, 32'd1);
    @(negedge clk);
    access(0, 1'b0, 4'd3, 8'h00, 8'hA5, n);
    check("t1_rd_latency", n, 32'd1);
    repeat (3) @(negedge clk);

    // 2: both ports hold reads continuously; grants must alternate p0,p1,p0,p1
    access(0, 1'b1, 4'd1, 8'h11, 8'h00, n);
    access(1, 1'b1, 4'd2, 8'h22, 8'h00, n);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      evq.push_back('{kind: i % 2, wr: 1'b0, addr: (i % 2 == 0) ? 4'd1 : 4'd2, data: 8'h00});
    end
    rdq0.push_back(8'h11); rdq0.push_back(8'h11);
    rdq1.push_back(8'h22); rdq1.push_back(8'h22);
    p0_wr = 1'b0; p0_addr = 4'd1; p0_req = 1'b1;
    p1_wr = 1'b0; p1_addr = 4'd2; p1_req = 1'b1;
    repeat (7) @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clk);

    // 3: fill with FF, then clear together with a port 1 request
    for (int a = 0; a < 16; a++) access(0, 1'b1, a[3:0], 8'hFF, 8'h00, n);
    @(negedge clk);
    evq.push_back('{kind: 2, wr: 1'b0, addr: 4'd0, data: 8'h00});
    clr_req = 1'b1;
    fork
      access(1, 1'b0, 4'd0, 8'h00, 8'h00, n);
      begin
        @(negedge clk);
        clr_req = 1'b0;
      end
    join
    check("t3_gnt_after_clr", n, 32'd3);
    for (int a = 1; a < 16; a++) access(1, 1'b0, a[3:0], 8'h00, 8'h00, n);
    repeat (3) @(negedge clk);

    // 4: async reset during the access cycle of a write must abort it
    access(0, 1'b1, 4'd5, 8'h3C, 8'h00, n);
    @(negedge clk);
    evq.push_back('{kind: 0, wr: 1'b1, addr: 4'd5, data: 8'h99});
    p0_wr = 1'b1; p0_addr = 4'd5; p0_wdata = 8'h99; p0_req = 1'b1;
    @(negedge clk);
    check("t4_gnt_before_rst", {31'd0, p0_gnt}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_we", {31'd0, ram_we}, 32'd0);
    check("t4_rst_gnt", {31'd0, p0_gnt}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_addr", {28'd0, ram_addr}, 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 4'd5, 8'h00, 8'h3C, n);
    check("t4_read_latency", n, 32'd1);
    repeat (3) @(negedge clk);

    // 6: a one-cycle p0 pulse during p1's access is never granted; a held request is
    access(1, 1'b0, 4'd3, 8'h00, 8'h00, n);
    p0_wr = 1'b0; p0_addr = 4'd7; p0_req = 1'b1;
    @(negedge clk);
    p0_req = 1'b0;
    repeat (4) @(negedge clk);
    access(0, 1'b0, 4'd7, 8'h00, 8'h00, n);
    check("t6_regrant_latency", n, 32'd1);
    repeat (4) @(negedge clk);

    check("evq_drained", evq.size(), 32'd0);
    check("rdq0_drained", rdq0.size(), 32'd0);
    check("rdq1_drained", rdq1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
